// File: rtl/secded_decoder.sv
// Two-stage SECDED decoder for 39-bit Hamming codewords carrying 32 data bits.
// Stage 1 captures the codeword with its syndrome and parity; stage 2 corrects and classifies.
module secded_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [38:0]      cw_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      data_out,
  output logic             err_corr,
  output logic             err_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam int STAGES = 2;

  typedef struct packed {
    logic [38:0] cw;
    logic [5:0]  syn;
    logic        par;
  } s1_t;

  typedef struct packed {
    logic [31:0] data;
    logic        corr;
    logic        uncorr;
  } s2_t;

  function automatic logic [5:0] syndrome(input logic [38:0] cw);
    logic [5:0] s;
    s = '0;
    for (int i = 1; i < 39; i++)
      if (cw[i]) s ^= i[5:0];
    return s;
  endfunction

  // Data bits sit at every non-power-of-two position, ascending.
  function automatic logic [31:0] extract(input logic [38:0] cw);
    return {cw[38:33], cw[31:17], cw[15:9], cw[7:5], cw[3]};
  endfunction

  logic [STAGES:1] vld_pipe;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic            s1_load, s2_load, fire;
  logic            syn_in_range;
  logic [38:0]     fix;

  assign s2_load  = !vld_pipe[2] || out_ready;
  assign s1_load  = !vld_pipe[1] || s2_load;
  assign in_ready = s1_load;
  assign fire     = vld_pipe[2] && out_ready;

  always_comb begin
    s1_d.cw  = cw_in;
    s1_d.syn = syndrome(cw_in);
    s1_d.par = ^cw_in;
  end

  // s==0 with odd parity is a bit-0 error: flagged, but no data bit moves.
  always_comb begin
    syn_in_range = (s1_q.syn < 6'd39);
    fix          = '0;
    if (s1_q.par && syn_in_range && (s1_q.syn != 6'd0))
      fix = 39'(1) << s1_q.syn;
    s2_d.data   = extract(s1_q.cw ^ fix);
    s2_d.corr   = s1_q.par && syn_in_range;
    s2_d.uncorr = (!s1_q.par && (s1_q.syn != 6'd0)) || (s1_q.par && !syn_in_range);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_pipe   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else begin
      if (s1_load) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
      // A clear in the same cycle as a counted word drops that event.
      if (cnt_clr) begin
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
      end else begin
        if (fire && s2_q.corr && (corr_cnt != '1))
          corr_cnt <= corr_cnt + CNT_W'(1);
        if (fire && s2_q.uncorr && (uncorr_cnt != '1))
          uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
    end
  end

  assign out_valid  = vld_pipe[2];
  assign data_out   = s2_q.data;
  assign err_corr   = s2_q.corr;
  assign err_uncorr = s2_q.uncorr;

endmodule
